// File: rtl/management_write_interface.sv
// management_write_interface
//
// Write path for the management register bank. A burst starts with a one-cycle
// wr_en strobe carrying the first byte address (wr_addr) and the byte count
// (wr_len). The data bytes then follow on wr_valid/wr_data, one per strobe,
// with no backpressure. Bytes are collected in a 32-bit staging word and
// merged into the addressed register in a single cycle. Fabric logic
// therefore never sees a partially written word.
//
// Ports:
//   clk            management clock
//   rst_n          asynchronous active-low reset
//   wr_en          burst start strobe (one cycle)
//   wr_addr[15:0]  first byte address of the burst
//   wr_len[15:0]   burst length in bytes
//   wr_valid       data byte strobe
//   wr_data[7:0]   data byte
//   wr_busy        burst in progress
//   wr_done        one-cycle pulse when a burst finishes
//   wr_err         error flag, valid together with wr_done
//   regs           register bank, register i at [32*i +: 32]
//   reg_wr_strobe  one-cycle pulse per register when it is committed
//
// Optional feature: define MGMT_WR_LOCK_EN to make register 0 a lock key.
// While it is enabled, commits to registers 1..NUM_REGS-1 are dropped unless
// register 0 holds LOCK_KEY. Register 0 itself can always be written.

module management_write_interface #(
  parameter int          NUM_REGS  = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter logic [31:0] LOCK_KEY  = 32'h4C4B4559
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [15:0]           wr_addr,
  input  logic [15:0]           wr_len,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  wr_err,
  output logic [NUM_REGS*32-1:0] regs,
  output logic [NUM_REGS-1:0]   reg_wr_strobe
);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  localparam logic [16:0] WINDOW_BYTES = 17'(4 * NUM_REGS);

  state_t                 state_q, state_d;
  logic [15:0]            ptr_q, ptr_d;
  logic [15:0]            remaining_q, remaining_d;
  logic                   err_q, err_d;
  logic [31:0]            stage_data_q, stage_data_d;
  logic [3:0]             stage_mask_q, stage_mask_d;
  logic [5:0]             stage_idx_q, stage_idx_d;
  logic [NUM_REGS*32-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]    strobe_q, strobe_d;
  logic                   wr_done_q, wr_done_d;
  logic                   wr_err_q, wr_err_d;

  // Decode of the current beat. The offset wraps modulo 2^16, so an address
  // below BASE_ADDR becomes a large offset and falls outside the window.
  logic [15:0] offset;
  logic [1:0]  lane;
  logic        in_range;
  logic        last_beat;
  logic        lock_ok;

  assign offset    = ptr_q - BASE_ADDR;
  assign lane      = ptr_q[1:0];
  assign in_range  = {1'b0, offset} < WINDOW_BYTES;
  assign last_beat = (remaining_q == 16'd1);

`ifdef MGMT_WR_LOCK_EN
  // The lock check uses the value register 0 holds before this beat's commit.
  assign lock_ok = (stage_idx_d == 6'd0) || (regs_q[31:0] == LOCK_KEY);
`else
  logic unused_lock_key;
  assign unused_lock_key = ^LOCK_KEY;
  assign lock_ok = 1'b1;
`endif

  // Next-state logic. A beat stages its byte, and it commits the staged word
  // when it fills lane 3 or ends the burst. Registers and strobes are written
  // on the clock edge that samples that beat.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    err_d        = err_q;
    stage_data_d = stage_data_q;
    stage_mask_d = stage_mask_q;
    stage_idx_d  = stage_idx_q;
    regs_d       = regs_q;
    strobe_d     = '0;
    wr_done_d    = 1'b0;
    wr_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          ptr_d       = wr_addr;
          remaining_d = wr_len;
          err_d       = 1'b0;
          if (wr_len == 16'd0) begin
            wr_done_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (wr_en) begin
          err_d = 1'b1;
        end
        if (wr_valid) begin
          if (in_range) begin
            stage_data_d[8*lane +: 8] = wr_data;
            stage_mask_d[lane]        = 1'b1;
            stage_idx_d               = offset[7:2];
          end else begin
            err_d = 1'b1;
          end
          ptr_d       = ptr_q + 16'd1;
          remaining_d = remaining_q - 16'd1;

          if ((lane == 2'd3) || last_beat) begin
            if (stage_mask_d != 4'd0) begin
              if (lock_ok) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (6'(i) == stage_idx_d) begin
                    strobe_d[i] = 1'b1;
                    for (int l = 0; l < 4; l++) begin
                      if (stage_mask_d[l]) begin
                        regs_d[32*i + 8*l +: 8] = stage_data_d[8*l +: 8];
                      end
                    end
                  end
                end
              end else begin
                err_d = 1'b1;
              end
            end
            stage_mask_d = 4'd0;
          end

          if (last_beat) begin
            state_d   = S_IDLE;
            wr_done_d = 1'b1;
            wr_err_d  = err_d;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register. An asynchronous reset discards any staged bytes, so no
  // partial commit can happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      err_q        <= 1'b0;
      stage_data_q <= '0;
      stage_mask_q <= '0;
      stage_idx_q  <= '0;
      regs_q       <= '0;
      strobe_q     <= '0;
      wr_done_q    <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      err_q        <= err_d;
      stage_data_q <= stage_data_d;
      stage_mask_q <= stage_mask_d;
      stage_idx_q  <= stage_idx_d;
      regs_q       <= regs_d;
      strobe_q     <= strobe_d;
      wr_done_q    <= wr_done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  assign wr_busy       = (state_q == S_DATA);
  assign wr_done       = wr_done_q;
  assign wr_err        = wr_err_q;
  assign regs          = regs_q;
  assign reg_wr_strobe = strobe_q;

endmodule

// File: tb/tb_management_write_interface.sv
// Self-checking bench for management_write_interface. It uses a table of
// bursts with hand-computed results, plus hand-written sequences for
// zero-length bursts, beats received while idle, and reset during a burst.

module tb_management_write_interface;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_len;
  logic         wr_valid;
  logic [7:0]   wr_data;
  logic         wr_busy;
  logic         wr_done;
  logic         wr_err;
  logic [255:0] regs;
  logic [7:0]   reg_wr_strobe;

  int errors;
  int checks;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] len;
    logic [31:0] bytes;
    logic        midEn;
    int          regIdx;
    logic [31:0] expReg;
    logic [7:0]  expStrobe;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  management_write_interface dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_len        (wr_len),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_busy       (wr_busy),
    .wr_done       (wr_done),
    .wr_err        (wr_err),
    .regs          (regs),
    .reg_wr_strobe (reg_wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] len,
                              input logic [31:0] bytes, input logic midEn,
                              input int regIdx, input logic [31:0] expReg,
                              input logic [7:0] expStrobe, input logic expErr);
    vec_t v;
    v.addr = addr; v.len = len; v.bytes = bytes; v.midEn = midEn;
    v.regIdx = regIdx; v.expReg = expReg; v.expStrobe = expStrobe; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one burst and checks busy, done/err on the last beat, the strobes
  // seen during the burst, the target register, and that done is a single pulse.
  task automatic applyStimulus(input vec_t v);
    logic [7:0] strobeSeen;
    strobeSeen = '0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = v.addr; wr_len = v.len;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("busy", {31'b0, wr_busy}, 32'd1);
    for (int k = 0; k < int'(v.len); k++) begin
      wr_valid = 1'b1;
      wr_data  = v.bytes[8*k +: 8];
      wr_en    = v.midEn && (k == 0);
      @(posedge clk); #1;
      strobeSeen |= reg_wr_strobe;
      if (k == int'(v.len) - 1) begin
        checkOutput("done", {31'b0, wr_done}, 32'd1);
        checkOutput("err", {31'b0, wr_err}, {31'b0, v.expErr});
      end
      @(negedge clk);
      wr_valid = 1'b0; wr_en = 1'b0;
    end
    checkOutput("strobe", {24'b0, strobeSeen}, {24'b0, v.expStrobe});
    checkOutput("reg", regs[32*v.regIdx +: 32], v.expReg);
    @(posedge clk); #1;
    checkOutput("donePulse", {31'b0, wr_done}, 32'd0);
    checkOutput("idleBusy", {31'b0, wr_busy}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_len = '0; wr_valid = 1'b0; wr_data = '0;

`ifdef MGMT_WR_LOCK_EN
    vecs.push_back(mk(16'h0104, 16'd4, 32'h44332211, 1'b0, 1, 32'h00000000, 8'h00, 1'b1));
    vecs.push_back(mk(16'h0100, 16'd4, 32'h4C4B4559, 1'b0, 0, 32'h4C4B4559, 8'h01, 1'b0));
    vecs.push_back(mk(16'h0104, 16'd4, 32'h44332211, 1'b0, 1, 32'h44332211, 8'h02, 1'b0));
    vecs.push_back(mk(16'h010C, 16'd2, 32'h00003412, 1'b1, 3, 32'h00003412, 8'h08, 1'b1));
`else
    vecs.push_back(mk(16'h0100, 16'd4, 32'h44332211, 1'b0, 0, 32'h44332211, 8'h01, 1'b0));
    vecs.push_back(mk(16'h0104, 16'd4, 32'h44332211, 1'b0, 1, 32'h44332211, 8'h02, 1'b0));
    vecs.push_back(mk(16'h0105, 16'd2, 32'h0000BBAA, 1'b0, 1, 32'h44BBAA11, 8'h02, 1'b0));
    vecs.push_back(mk(16'h011E, 16'd4, 32'hC4C3C2C1, 1'b0, 7, 32'hC2C10000, 8'h80, 1'b1));
    vecs.push_back(mk(16'h0108, 16'd3, 32'h00030201, 1'b0, 2, 32'h00030201, 8'h04, 1'b0));
    vecs.push_back(mk(16'h00FF, 16'd2, 32'h000055EE, 1'b0, 0, 32'h44332255, 8'h01, 1'b1));
    vecs.push_back(mk(16'h0102, 16'd4, 32'hF0DEBC9A, 1'b0, 1, 32'h44BBF0DE, 8'h03, 1'b0));
    vecs.push_back(mk(16'h010C, 16'd2, 32'h00003412, 1'b1, 3, 32'h00003412, 8'h08, 1'b1));
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {31'b0, wr_busy}, 32'd0);
    checkOutput("rstDone", {31'b0, wr_done}, 32'd0);
    checkOutput("rstErr", {31'b0, wr_err}, 32'd0);
    checkOutput("rstStrobe", {24'b0, reg_wr_strobe}, 32'd0);
    checkOutput("rstRegs", {31'b0, |regs}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Beat in IDLE after the burst has completed: ignored.
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'hFF;
    @(posedge clk); #1;
    checkOutput("idleBeatStrobe", {24'b0, reg_wr_strobe}, 32'd0);
    checkOutput("idleBeatReg", regs[32*3 +: 32], 32'h00003412);
    @(negedge clk);
    wr_valid = 1'b0;

    // Zero-length burst: done on the next cycle, no error, no strobe.
    wr_en = 1'b1; wr_addr = 16'h0100; wr_len = 16'd0;
    @(posedge clk); #1;
    checkOutput("len0Done", {31'b0, wr_done}, 32'd1);
    checkOutput("len0Err", {31'b0, wr_err}, 32'd0);
    checkOutput("len0Strobe", {24'b0, reg_wr_strobe}, 32'd0);
    checkOutput("len0Busy", {31'b0, wr_busy}, 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    checkOutput("len0Pulse", {31'b0, wr_done}, 32'd0);

    // Reset after 2 of 4 bytes: everything clears and nothing is committed.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 16'h0110; wr_len = 16'd4;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1; wr_data = 8'h5A;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstRegs", {31'b0, |regs}, 32'd0);
    checkOutput("midRstBusy", {31'b0, wr_busy}, 32'd0);
    checkOutput("midRstStrobe", {24'b0, reg_wr_strobe}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(16'h0100, 16'd4, 32'h44332211, 1'b0, 0, 32'h44332211, 8'h01, 1'b0));
    checkOutput("postRstReg4", regs[32*4 +: 32], 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
